conv_operand_pingpong_buffer: RTL

- Parametrised, double-buffered operand store for the convolution datapath. Holds one NxN data tile and one KxK filter per bank.
- Operands arrive as a serial element stream (valid/ready) and fill a shadow bank.
- A full shadow bank is swapped to active when the compute stage releases the current set, so loading overlaps computation.
- Active bank contents are presented as flattened buses to the MAC array.

---
 rtl/conv_operand_pingpong_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/conv_operand_pingpong_buffer.sv
// rtl/conv_operand_pingpong_buffer.sv - double-buffered data tile / filter store for the conv MAC array
// Serial elements fill the shadow bank; a complete shadow bank swaps to active on release.
module conv_operand_pingpong_buffer #(
   parameter int DW = 8,
   parameter int N  = 4,
   parameter int K  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sel,
   input  logic [DW-1:0]       in_data,
   input  logic                clr,
   input  logic                out_consume,
   output logic                out_valid,
   output logic                load_done,
   output logic [N*N*DW-1:0]   data_flat,
   output logic [K*K*DW-1:0]   filt_flat,
   output logic                shadow_full
);

   localparam int NN  = N * N;
   localparam int KK  = K * K;
   localparam int DCW = $clog2(NN + 1);
   localparam int FCW = $clog2(KK + 1);
   localparam int DIW = (NN > 1) ? $clog2(NN) : 1;
   localparam int FIW = (KK > 1) ? $clog2(KK) : 1;
   localparam logic [DCW-1:0] D_FULL = DCW'(NN);
   localparam logic [FCW-1:0] F_FULL = FCW'(KK);

   logic [DW-1:0]  data_mem_q [0:1][0:NN-1];
   logic [DW-1:0]  filt_mem_q [0:1][0:KK-1];

   logic           ptr_q, ptr_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           out_valid_q, out_valid_d;
   logic           load_done_q, load_done_d;

   logic           d_room, f_room, accept, wr_data, wr_filt, swap;
   logic           shadow_sel;
   logic [DIW-1:0] d_idx;
   logic [FIW-1:0] f_idx;

   // Stream handshake and swap decision, all combinational from the counters.
   always_comb begin
      d_room      = (dcnt_q < D_FULL);
      f_room      = (fcnt_q < F_FULL);
      in_ready    = (in_sel ? f_room : d_room) & ~rst;
      shadow_full = (dcnt_q == D_FULL) & (fcnt_q == F_FULL);
      accept      = in_valid & in_ready & ~clr;
      wr_data     = accept & ~in_sel;
      wr_filt     = accept & in_sel;
      swap        = shadow_full & (~out_valid_q | out_consume) & ~clr;
      shadow_sel  = ~ptr_q;
      d_idx       = dcnt_q[DIW-1:0];
      f_idx       = fcnt_q[FIW-1:0];
   end

   always_comb begin
      ptr_d       = ptr_q ^ swap;
      dcnt_d      = dcnt_q;
      fcnt_d      = fcnt_q;
      if (clr || swap) begin
         dcnt_d = '0;
         fcnt_d = '0;
      end else begin
         if (wr_data) dcnt_d = dcnt_q + 1'b1;
         if (wr_filt) fcnt_d = fcnt_q + 1'b1;
      end
      out_valid_d = out_valid_q;
      if (swap)             out_valid_d = 1'b1;
      else if (out_consume) out_valid_d = 1'b0;
      load_done_d = swap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= 1'b0;
         dcnt_q      <= '0;
         fcnt_q      <= '0;
         out_valid_q <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         dcnt_q      <= dcnt_d;
         fcnt_q      <= fcnt_d;
         out_valid_q <= out_valid_d;
         load_done_q <= load_done_d;
      end
   end

   // Writes only ever target the shadow bank; the active bank is read-only here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NN; i++) data_mem_q[b][i] <= '0;
            for (int i = 0; i < KK; i++) filt_mem_q[b][i] <= '0;
         end
      end else begin
         if (wr_data) data_mem_q[shadow_sel][d_idx] <= in_data;
         if (wr_filt) filt_mem_q[shadow_sel][f_idx] <= in_data;
      end
   end

   always_comb begin
      data_flat = '0;
      filt_flat = '0;
      for (int i = 0; i < NN; i++) data_flat[i*DW +: DW] = data_mem_q[ptr_q][i];
      for (int i = 0; i < KK; i++) filt_flat[i*DW +: DW] = filt_mem_q[ptr_q][i];
   end

   assign out_valid = out_valid_q;
   assign load_done = load_done_q;

endmodule
